// File: rtl/sdram_host_responder_if.sv
// rtl/sdram_host_responder_if.sv - host request/response bundle for the SDRAM responder
interface sdram_host_responder_if;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic [23:0] rd_addr;
    logic        rd_enable;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic        busy;
    logic        req_drop;

    modport master (
        output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
        input  rd_data, rd_ready, busy, req_drop
    );

    modport slave (
        input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
        output rd_data, rd_ready, busy, req_drop
    );
endinterface

// File: rtl/sdram_host_responder.sv
// rtl/sdram_host_responder.sv - host-side responder modelling SDRAM write/read/refresh timing
module sdram_host_responder #(
    parameter int ADDR_BITS      = 8,
    parameter int WR_LATENCY     = 2,
    parameter int RD_LATENCY     = 3,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_host_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int RBITS = $clog2(REFRESH_PERIOD);
    localparam logic [3:0] WR_INIT  = 4'(WR_LATENCY - 1);
    localparam logic [3:0] RD_INIT  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] REF_INIT = 4'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} state_t;

    state_t               state, state_nx;
    logic [3:0]           op_cnt, op_cnt_nx;
    logic                 pending, pending_nx;
    logic [RBITS-1:0]     ref_cnt;
    logic [ADDR_BITS-1:0] raddr;
    logic                 rd_ready_q, ready_nx;
    logic [15:0]          rd_data_q, rd_word;
    logic                 drop_q, drop_nx;
    logic                 busy_int, accept, acc_wr, acc_rd, wrap, refresh_due;

    logic [15:0] mem [DEPTH] = '{default: 16'h0000};

    // High address bits alias onto the decoded range by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.wr_addr[23:ADDR_BITS], bus.rd_addr[23:ADDR_BITS]};

    assign busy_int    = (state != IDLE) || pending;
    assign accept      = !busy_int;
    assign acc_wr      = accept && bus.wr_enable;
    assign acc_rd      = accept && bus.rd_enable && !bus.wr_enable;
    assign wrap        = (ref_cnt == RBITS'(REFRESH_PERIOD - 1));
    assign refresh_due = pending || wrap;
    assign drop_nx     = (busy_int && (bus.wr_enable || bus.rd_enable)) ||
                         (acc_wr && bus.rd_enable);
    assign rd_word     = (state == IDLE) ? mem[bus.rd_addr[ADDR_BITS-1:0]] : mem[raddr];

    assign bus.busy     = busy_int;
    assign bus.rd_ready = rd_ready_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.req_drop = drop_q;

    // A wrap seen while idle goes straight to REFRESH so the refresh window
    // is exactly REFRESH_CYCLES long; operations chain into REFRESH likewise.
    always_comb begin
        state_nx   = state;
        op_cnt_nx  = op_cnt;
        pending_nx = pending || wrap;
        ready_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (acc_wr) begin
                    state_nx  = WRITE;
                    op_cnt_nx = WR_INIT;
                end else if (acc_rd) begin
                    state_nx  = READ;
                    op_cnt_nx = RD_INIT;
                    ready_nx  = (RD_LATENCY == 1);
                end else if (refresh_due) begin
                    state_nx   = REFRESH;
                    op_cnt_nx  = REF_INIT;
                    pending_nx = 1'b0;
                end
            end
            default: begin
                if (state == READ && op_cnt == 4'd1)
                    ready_nx = 1'b1;
                if (op_cnt == 4'd0) begin
                    if (refresh_due) begin
                        state_nx   = REFRESH;
                        op_cnt_nx  = REF_INIT;
                        pending_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    op_cnt_nx = op_cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_cnt     <= 4'd0;
            pending    <= 1'b0;
            ref_cnt    <= '0;
            raddr      <= '0;
            rd_ready_q <= 1'b0;
            rd_data_q  <= 16'h0000;
            drop_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            op_cnt     <= op_cnt_nx;
            pending    <= pending_nx;
            ref_cnt    <= wrap ? '0 : ref_cnt + RBITS'(1);
            rd_ready_q <= ready_nx;
            drop_q     <= drop_nx;
            if (acc_rd)
                raddr <= bus.rd_addr[ADDR_BITS-1:0];
            if (ready_nx)
                rd_data_q <= rd_word;
        end
    end

    // Storage survives reset; only accepted writes outside reset commit.
    always_ff @(posedge clk) begin
        if (rst_n && acc_wr)
            mem[bus.wr_addr[ADDR_BITS-1:0]] <= bus.wr_data;
    end
endmodule

// File: tb/tb_sdram_host_responder.sv
// tb/tb_sdram_host_responder.sv - scoreboard bench for sdram_host_responder
module tb_sdram_host_responder;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_host_responder_if bus();

    sdram_host_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int r0 = 0;
    int rq_cyc[$];
    logic [15:0] rq_data[$];
    int dq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (rq_cyc.size() > 0 && rq_cyc[0] < cyc) begin
            checks++; errors++;
            $display("FAIL rd_ready_missing: got none expected pulse at cycle %0d", rq_cyc[0]);
            void'(rq_cyc.pop_front());
            void'(rq_data.pop_front());
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL req_drop_missing: got none expected pulse at cycle %0d", dq[0]);
            void'(dq.pop_front());
        end
        if (bus.rd_ready === 1'b1) begin
            if (rq_cyc.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_ready_unexpected: got pulse expected none at cycle %0d", cyc);
            end else begin
                check("rd_ready_cycle", cyc, rq_cyc[0]);
                check("rd_data", bus.rd_data, rq_data[0]);
                void'(rq_cyc.pop_front());
                void'(rq_data.pop_front());
            end
        end
        if (bus.req_drop === 1'b1) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_drop_unexpected: got pulse expected none at cycle %0d", cyc);
            end else begin
                check("req_drop_cycle", cyc, dq[0]);
                void'(dq.pop_front());
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [23:0] wa, input logic [15:0] wd,
                         input logic [23:0] ra, input logic exp_rd, input logic [15:0] rdv,
                         input logic exp_drop, output int acc);
        acc = cyc + 1;
        bus.wr_enable = w;
        bus.rd_enable = r;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_addr   = ra;
        if (exp_rd) begin
            rq_cyc.push_back(acc + RD_LAT - 1);
            rq_data.push_back(rdv);
        end
        if (exp_drop) dq.push_back(acc);
        @(negedge clk);
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy=%b expected 0 within 40 cycles", bus.busy);
        end
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("align_cycle", cyc, target);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int a;
        bus.wr_enable = 1'b1;
        bus.rd_enable = 1'b1;
        bus.wr_addr   = 24'h000005;
        bus.wr_data   = 16'h7777;
        bus.rd_addr   = 24'h000005;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_rd_ready", bus.rd_ready, 0);
        check("reset_req_drop", bus.req_drop, 0);
        check("reset_rd_data", bus.rd_data, 0);
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        rst_n = 1'b1;
        r0 = cyc;

        // idle refresh windows: 4 busy cycles after each wrap, every 64 cycles
        while (cyc <= r0 + 140) begin
            int d;
            d = cyc - r0;
            check("refresh_busy", bus.busy, (d >= 64 && (d % 64) < 4) ? 1 : 0);
            @(negedge clk);
        end

        // write then immediate aliased read
        wait_idle();
        issue(1, 0, 24'hFEDBED, 16'h0D05, 24'h0, 0, 16'h0, 0, a);
        check("wr_busy_1", bus.busy, 1);
        @(negedge clk);
        check("wr_busy_2", bus.busy, 1);
        @(negedge clk);
        check("wr_busy_end", bus.busy, 0);
        issue(0, 1, 24'h0, 16'h0, 24'h0000ED, 1, 16'h0D05, 0, a);

        // simultaneous write and read: write wins, read dropped
        wait_idle();
        issue(1, 1, 24'h000010, 16'hBEEF, 24'h000010, 0, 16'h0, 1, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000010, 1, 16'hBEEF, 0, a);

        // requests while busy are dropped and change nothing
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000010, 1, 16'hBEEF, 0, a);
        issue(0, 1, 24'h0, 16'h0, 24'h0000ED, 0, 16'h0, 1, a);
        issue(1, 0, 24'h000010, 16'hDEAD, 24'h0, 0, 16'h0, 1, a);

        // aliasing, reset-time write ignored, busy write ignored
        wait_idle();
        issue(1, 0, 24'h123456, 16'hA5A5, 24'h0, 0, 16'h0, 0, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'hFFFF56, 1, 16'hA5A5, 0, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000005, 1, 16'h0000, 0, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000010, 1, 16'hBEEF, 0, a);

        // read accepted on the wrap edge, refresh follows without gap
        wait_until(r0 + 191);
        check("pre_wrap_busy", bus.busy, 0);
        issue(0, 1, 24'h0, 16'h0, 24'h0000ED, 1, 16'h0D05, 0, a);
        for (int i = 0; i < 7; i++) begin
            check("wrap_read_busy", bus.busy, 1);
            @(negedge clk);
        end
        check("wrap_read_idle", bus.busy, 0);
        check("rd_data_hold", bus.rd_data, 16'h0D05);

        // reset during READ aborts without rd_ready, storage kept
        wait_idle();
        issue(1, 0, 24'h000020, 16'h1357, 24'h0, 0, 16'h0, 0, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000020, 0, 16'h0, 0, a);
        check("abort_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_rd_ready", bus.rd_ready, 0);
        check("abort_rd_data", bus.rd_data, 0);
        check("abort_req_drop", bus.req_drop, 0);
        rst_n = 1'b1;
        r0 = cyc;
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h000020, 1, 16'h1357, 0, a);
        wait_idle();
        issue(0, 1, 24'h0, 16'h0, 24'h0000ED, 1, 16'h0D05, 0, a);

        repeat (8) @(negedge clk);
        check("rd_queue_empty", rq_cyc.size(), 0);
        check("drop_queue_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
